// File: rtl/controller_poll_sched_if.sv
// Controller poll link: start/button bytes to the serial interface, status
// flags, and the CPU register read port.
interface controller_poll_sched_if #(
  parameter int NUM_CONTROLLERS = 2
);
  localparam int AW = $clog2(2 * NUM_CONTROLLERS);

  logic                         start;
  logic [8*NUM_CONTROLLERS-1:0] buttons_in;
  logic                         busy;
  logic                         poll_done;
  logic [AW-1:0]                reg_addr;
  logic                         rd_en;
  logic [7:0]                   reg_data;

  modport master (input start, busy, poll_done, reg_data,
                  output buttons_in, reg_addr, rd_en);
  modport slave  (output start, busy, poll_done, reg_data,
                  input buttons_in, reg_addr, rd_en);
endinterface

// File: rtl/controller_poll_sched.sv
// Frame/software poll sequencer for the controller interface; held and
// newly-pressed button registers. CONTROLLER_POLL_SCHED_EDGE_EN builds pressed + read-to-clear.
module controller_poll_sched #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int BUSY_CYCLES     = 9,
  parameter int SETTLE_CYCLES   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_enable,
  input  logic frame_tick,
  input  logic poll_req,
  controller_poll_sched_if.slave bus
);
  localparam int CMAX = (BUSY_CYCLES > SETTLE_CYCLES) ? BUSY_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, START, SETTLE, CAPTURE} state_t;

  state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic    pending, pending_nxt;
  logic    trig, cap;
  logic [NUM_CONTROLLERS-1:0][7:0] held;

  assign trig = clk_enable & (frame_tick | poll_req);
  assign cap  = clk_enable & (state == CAPTURE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else if (clk_enable) begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pending_nxt   = pending;
    bus.start     = 1'b0;
    bus.busy      = 1'b1;
    bus.poll_done = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (trig) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        bus.start   = 1'b1;
        pending_nxt = pending | trig;
        if (cnt == CW'(BUSY_CYCLES - 1)) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SETTLE: begin
        pending_nxt = pending | trig;
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state_nxt = CAPTURE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CAPTURE: begin
        bus.poll_done = 1'b1;
        // A trigger landing on the capture cycle either starts the next poll
        // directly or becomes the single queued one.
        if (pending | trig) begin
          state_nxt   = START;
          cnt_nxt     = '0;
          pending_nxt = pending & trig;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     held <= '0;
    else if (cap) held <= bus.buttons_in;
  end

`ifdef CONTROLLER_POLL_SCHED_EDGE_EN
  logic [NUM_CONTROLLERS-1:0][7:0] pressed;
  logic [NUM_CONTROLLERS-1:0]      clr;
  logic [NUM_CONTROLLERS-1:0][7:0] btn;

  assign btn = bus.buttons_in;

  for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_clr
    assign clr[k] = clk_enable & bus.rd_en & (int'(bus.reg_addr) == NUM_CONTROLLERS + k);
  end

  // Clear only drops old bits; edges found by a same-edge capture survive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pressed <= '0;
    end else if (clk_enable) begin
      for (int k = 0; k < NUM_CONTROLLERS; k++)
        pressed[k] <= (pressed[k] & ~{8{clr[k]}}) | (cap ? (btn[k] & ~held[k]) : 8'h00);
    end
  end
`else
  logic unused_rd_en;
  assign unused_rd_en = bus.rd_en;
`endif

  always_comb begin
    bus.reg_data = 8'h00;
    for (int k = 0; k < NUM_CONTROLLERS; k++) begin
      if (int'(bus.reg_addr) == k) bus.reg_data = held[k];
`ifdef CONTROLLER_POLL_SCHED_EDGE_EN
      if (int'(bus.reg_addr) == NUM_CONTROLLERS + k) bus.reg_data = pressed[k];
`endif
    end
  end
endmodule
